adex_spike_event_reader: RTL and testbench

// - Receive end of the AdEx neuron output bus: samples {spike, vmem[6:0]} and w[7:0].
// - Turns each spike rising edge into a timestamped event word {first, sat, isi, w_snap}.
// - Events are buffered in a small FIFO and drained by a host over valid/ready.
// - Also keeps running spike, drop and overflow statistics.

---
 rtl/adex_pkg.sv | 15 +
 rtl/adex_event_fifo.sv | 63 ++++++
 rtl/adex_spike_event_reader.sv | 128 ++++++++++++
 tb/tb_adex_spike_event_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adex_pkg.sv
// rtl/adex_pkg.sv - shared constants for the AdEx spike event reader
package adex_pkg;

    localparam int ISI_W_DEF        = 16;
    localparam int NEURON_SPIKE_BIT = 7;

    // Event word layout at the default ISI width, MSB first:
    // {first, sat, isi[ISI_W-1:0], w_snap[7:0]}
    localparam int EVT_W       = ISI_W_DEF + 10;
    localparam int EVT_FIRST   = EVT_W - 1;
    localparam int EVT_SAT     = EVT_W - 2;
    localparam int EVT_ISI_LSB = 8;
    localparam int EVT_W_LSB   = 0;

endpackage

// File: rtl/adex_event_fifo.sv
// rtl/adex_event_fifo.sv - synchronous first-word-fall-through event FIFO
module adex_event_fifo
    import adex_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        dout = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy registers; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/adex_spike_event_reader.sv
// rtl/adex_spike_event_reader.sv - AdEx spike edge to timestamped event reader
module adex_spike_event_reader
    import adex_pkg::*;
#(
    parameter int ISI_W      = ISI_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        neuron_out,
    input  logic [7:0]        neuron_w,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ISI_W+9:0]  evt_data,
    output logic [15:0]       spike_cnt,
    output logic [7:0]        drop_cnt,
    output logic              overflow,
    input  logic              clr_stat
);

    localparam int EW        = EVT_W - ISI_W_DEF + ISI_W;
    localparam int FIRST_BIT = EVT_FIRST - ISI_W_DEF + ISI_W;
    localparam int SAT_BIT   = EVT_SAT - ISI_W_DEF + ISI_W;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};

    logic             s1_q, s2_q;
    logic [7:0]       w1_q;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic             first_pend_q, first_pend_d;
    logic [15:0]      spike_cnt_q, spike_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic             spike_edge, capture, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [EW-1:0]    evt_word, fifo_dout;
    logic             vmem_unused;

    // vmem bits ride along on the bus but carry nothing the event needs.
    assign vmem_unused = ^neuron_out[6:0];

    // Input sampler; runs regardless of en so re-enabling never sees a stale edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            w1_q <= '0;
        end else begin
            s1_q <= neuron_out[NEURON_SPIKE_BIT];
            s2_q <= s1_q;
            w1_q <= neuron_w;
        end
    end

    // Edge detect, ISI counting, event assembly and statistics next-state.
    always_comb begin
        spike_edge = s1_q & ~s2_q;
        capture    = spike_edge & en;
        pop        = ~fifo_empty & evt_ready;
        drop       = capture & fifo_full & ~pop;

        isi_d = isi_q;
        if (en) begin
            if (spike_edge) begin
                isi_d = ISI_ONE;
            end else if (isi_q != ISI_MAX) begin
                isi_d = isi_q + 1'b1;
            end
        end

        first_pend_d = capture ? 1'b0 : first_pend_q;

        evt_word                            = '0;
        evt_word[FIRST_BIT]                 = first_pend_q;
        evt_word[SAT_BIT]                   = (isi_q == ISI_MAX);
        evt_word[EVT_ISI_LSB +: ISI_W]      = isi_q;
        evt_word[EVT_W_LSB +: 8]            = w1_q;

        spike_cnt_d = capture ? spike_cnt_q + 16'd1 : spike_cnt_q;
        drop_cnt_d  = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        overflow_d  = overflow_q | drop;
        if (clr_stat) begin
            spike_cnt_d = '0;
            drop_cnt_d  = '0;
            overflow_d  = 1'b0;
        end
    end

    // Counter and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_q        <= '0;
            first_pend_q <= 1'b1;
            spike_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            isi_q        <= isi_d;
            first_pend_q <= first_pend_d;
            spike_cnt_q  <= spike_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    adex_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (evt_word),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_data  = fifo_empty ? '0 : fifo_dout;
    assign spike_cnt = spike_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_adex_spike_event_reader.sv
// tb/tb_adex_spike_event_reader.sv - self-checking bench for adex_spike_event_reader
module tb_adex_spike_event_reader;

    localparam int DEPTH   = 8;
    localparam int ISI_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  neuron_out = '0;
    logic [7:0]  neuron_w = '0;
    logic        evt_ready = 1'b0;
    logic        clr_stat = 1'b0;

    logic        evt_valid;
    logic [25:0] evt_data;
    logic [15:0] spike_cnt;
    logic [7:0]  drop_cnt;
    logic        overflow;

    logic        v8;
    logic [17:0] d8;
    logic [15:0] sc8;
    logic [7:0]  dc8;
    logic        ov8;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    bit          m_s1, m_s2, m_first, m_ovf;
    logic [7:0]  m_w1;
    int          m_isi, m_spk, m_drop;
    logic [25:0] m_q[$];

    always #5 clk = ~clk;

    adex_spike_event_reader #(.ISI_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .neuron_out(neuron_out), .neuron_w(neuron_w),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .spike_cnt(spike_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .clr_stat(clr_stat)
    );

    adex_spike_event_reader #(.ISI_W(8), .FIFO_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .en(en), .neuron_out(neuron_out), .neuron_w(neuron_w),
        .evt_valid(v8), .evt_ready(evt_ready), .evt_data(d8),
        .spike_cnt(sc8), .drop_cnt(dc8), .overflow(ov8), .clr_stat(clr_stat)
    );

    // Advance the model with the inputs the DUT is about to sample, then clock.
    task automatic tick();
        bit ed, pop, cap;
        logic [25:0] word;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_w1 = '0; m_isi = 0; m_first = 1;
            m_q.delete(); m_spk = 0; m_drop = 0; m_ovf = 0;
        end else begin
            ed   = m_s1 && !m_s2;
            cap  = ed && en;
            pop  = (m_q.size() != 0) && evt_ready;
            word = {m_first, (m_isi == ISI_MAX), 16'(m_isi), m_w1};
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                m_spk = (m_spk + 1) % 65536;
                if (m_q.size() == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end else begin
                    m_q.push_back(word);
                end
                m_first = 0;
            end
            if (en) m_isi = ed ? 1 : ((m_isi < ISI_MAX) ? m_isi + 1 : ISI_MAX);
            if (clr_stat) begin m_spk = 0; m_drop = 0; m_ovf = 0; end
            m_s2 = m_s1; m_s1 = neuron_out[7]; m_w1 = neuron_w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_spike(input bit s);
        neuron_out = {s, 7'($urandom)};
    endtask

    task automatic test_reset();
        rst = 1; en = 0; evt_ready = 0; clr_stat = 0; set_spike(0);
        tick(); tick();
        rst = 0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        n_cmp++; if (evt_data !== 26'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", evt_data); end
        n_cmp++; if (spike_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_spike_cnt: got %0d want 0", spike_cnt); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_pulses();
        logic [25:0] got[$];
        en = 1; evt_ready = 1;
        for (int t = 0; t < 60; t++) begin
            set_spike((t >= 10 && t < 15) || (t >= 40 && t < 45));
            neuron_w = 8'($urandom);
            tick();
            if (evt_valid && evt_ready) got.push_back(evt_data);
            n_cmp++;
            if (evt_valid !== (m_q.size() != 0) || (m_q.size() != 0 && evt_data !== m_q[0])) begin
                n_fail++; $display("FAIL pulses_head t=%0d: got %b/%h model %0d entries", t, evt_valid, evt_data, m_q.size());
            end
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_fail++; $display("FAIL pulses_count: got %0d want 2", got.size());
        end else begin
            n_cmp++; if (got[0][25] !== 1'b1) begin n_fail++; $display("FAIL pulses_first0: got %b want 1", got[0][25]); end
            n_cmp++; if (got[1][25] !== 1'b0) begin n_fail++; $display("FAIL pulses_first1: got %b want 0", got[1][25]); end
            n_cmp++; if (got[1][23:8] !== 16'd30) begin n_fail++; $display("FAIL pulses_isi: got %0d want 30", got[1][23:8]); end
            n_cmp++; if (got[1][24] !== 1'b0) begin n_fail++; $display("FAIL pulses_sat: got %b want 0", got[1][24]); end
        end
        n_cmp++; if (spike_cnt !== 16'd2) begin n_fail++; $display("FAIL pulses_spike_cnt: got %0d want 2", spike_cnt); end
    endtask

    task automatic test_w_capture();
        en = 1; evt_ready = 1; set_spike(0);
        repeat (3) tick();
        set_spike(1); neuron_w = 8'h5A;
        tick();
        neuron_w = 8'h00;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL wcap_early_valid: got %b want 0", evt_valid); end
        tick();
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL wcap_valid_2clk: got %b want 1", evt_valid); end
        n_cmp++; if (evt_data[7:0] !== 8'h5A) begin n_fail++; $display("FAIL wcap_w_snap: got %h want 5a", evt_data[7:0]); end
        set_spike(0);
        repeat (3) tick();
    endtask

    task automatic test_overflow_and_clear();
        int pops;
        en = 1; evt_ready = 0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_start_empty: got %b want 0", evt_valid); end
        for (int i = 0; i < 10; i++) begin
            set_spike(1); tick(); tick();
            set_spike(0); tick(); tick();
        end
        tick();
        n_cmp++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (spike_cnt !== 16'(m_spk)) begin n_fail++; $display("FAIL ovf_spike_cnt: got %0d want %0d", spike_cnt, m_spk); end
        n_cmp++; if (evt_data !== m_q[0]) begin n_fail++; $display("FAIL ovf_head_steady: got %h want %h", evt_data, m_q[0]); end
        // a drop lands in the same cycle as clr_stat
        set_spike(1); tick();
        clr_stat = 1; tick();
        clr_stat = 0; set_spike(0); tick();
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", overflow); end
        n_cmp++; if (spike_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_spike_cnt: got %0d want 0", spike_cnt); end
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL clr_fifo_kept: got %b want 1", evt_valid); end
        evt_ready = 1; pops = 0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (evt_valid !== (m_q.size() != 0) || (m_q.size() != 0 && evt_data !== m_q[0])) begin
                n_fail++; $display("FAIL drain_order i=%0d: got %b/%h model %0d entries", i, evt_valid, evt_data, m_q.size());
            end
            if (evt_valid) pops++;
            tick();
        end
        n_cmp++; if (pops != DEPTH) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", pops, DEPTH); end
    endtask

    task automatic test_enable_gating();
        bit seen = 0;
        evt_ready = 1; en = 0; set_spike(1);
        repeat (3) tick();
        en = 1;
        repeat (4) begin tick(); if (evt_valid) seen = 1; end
        set_spike(0);
        repeat (3) begin tick(); if (evt_valid) seen = 1; end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL gate_no_event: got event want none"); end
        n_cmp++; if (spike_cnt !== 16'd0) begin n_fail++; $display("FAIL gate_spike_cnt: got %0d want 0", spike_cnt); end
    endtask

    task automatic test_random();
        bit s = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            set_spike(s);
            neuron_w  = 8'($urandom);
            en        = ($urandom_range(0, 9) != 0);
            evt_ready = ($urandom_range(0, 2) == 0);
            clr_stat  = ($urandom_range(0, 49) == 0);
            tick();
            n_cmp++;
            if (evt_valid !== (m_q.size() != 0) || (m_q.size() != 0 && evt_data !== m_q[0]) ||
                spike_cnt !== 16'(m_spk) || drop_cnt !== 8'(m_drop) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random i=%0d: got v=%b d=%h sc=%0d dc=%0d ov=%b want d=%h sc=%0d dc=%0d ov=%b",
                         i, evt_valid, evt_data, spike_cnt, drop_cnt, overflow,
                         (m_q.size() != 0) ? m_q[0] : 26'd0, m_spk, m_drop, m_ovf);
            end
        end
        clr_stat = 0;
    endtask

    task automatic test_saturation();
        logic [17:0] got8[$];
        logic [25:0] got[$];
        rst = 1; tick(); rst = 0;
        en = 1; evt_ready = 1;
        for (int t = 0; t < 320; t++) begin
            set_spike((t < 3) || (t >= 300 && t < 303));
            tick();
            if (v8) got8.push_back(d8);
            if (evt_valid) got.push_back(evt_data);
        end
        n_cmp++;
        if (got8.size() != 2) begin
            n_fail++; $display("FAIL sat_count: got %0d want 2", got8.size());
        end else begin
            n_cmp++; if (got8[0][17] !== 1'b1) begin n_fail++; $display("FAIL sat_first0: got %b want 1", got8[0][17]); end
            n_cmp++; if (got8[1][17] !== 1'b0) begin n_fail++; $display("FAIL sat_first1: got %b want 0", got8[1][17]); end
            n_cmp++; if (got8[1][16] !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", got8[1][16]); end
            n_cmp++; if (got8[1][15:8] !== 8'd255) begin n_fail++; $display("FAIL sat_isi: got %0d want 255", got8[1][15:8]); end
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_fail++; $display("FAIL wide_count: got %0d want 2", got.size());
        end else begin
            n_cmp++; if (got[1][23:8] !== 16'd300 || got[1][24] !== 1'b0) begin
                n_fail++; $display("FAIL wide_isi: got %0d sat %b want 300 sat 0", got[1][23:8], got[1][24]);
            end
        end
    endtask

    task automatic test_reset_midop();
        en = 1; evt_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_spike(1); tick(); tick();
            set_spike(0); tick();
        end
        tick();
        n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_queued: got %b want 1", evt_valid); end
        rst = 1; tick(); rst = 0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", evt_valid); end
        n_cmp++; if (spike_cnt !== 16'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stats: got sc=%0d dc=%0d ov=%b want 0 0 0", spike_cnt, drop_cnt, overflow);
        end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_empty: got %b want 0", evt_valid); end
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_w_capture();
        test_overflow_and_clear();
        test_enable_gating();
        test_random();
        test_saturation();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
